// File: rtl/mux_n_1_pipe_if.sv
// Handshake bundle for mux_n_1_pipe: flattened operand channels plus select
// on the input side, one registered operand on the output side.
// master = producer/consumer side (drives in_*, flush, out_ready);
// slave = the mux (drives in_ready, out_*, and sel_err when MUX_SEL_ERR_EN is defined).
interface mux_n_1_pipe_if #(
  parameter int WIDTH = 32,
  parameter int N     = 4
);
  localparam int SELW = $clog2(N);

  logic [N*WIDTH-1:0] in_data;
  logic [SELW-1:0]    sel;
  logic               in_valid;
  logic               in_ready;
  logic               flush;
  logic [WIDTH-1:0]   out_data;
  logic               out_valid;
  logic               out_ready;
`ifdef MUX_SEL_ERR_EN
  logic               sel_err;
`endif

  modport master (
    output in_data, sel, in_valid, flush, out_ready,
    input  in_ready, out_data, out_valid
`ifdef MUX_SEL_ERR_EN
    , input sel_err
`endif
  );

  modport slave (
    input  in_data, sel, in_valid, flush, out_ready,
    output in_ready, out_data, out_valid
`ifdef MUX_SEL_ERR_EN
    , output sel_err
`endif
  );
endinterface

// File: rtl/mux_n_1_pipe.sv
// Purpose: N:1 WIDTH-bit operand select with a registered output and a one-entry skid buffer.
// Latency: one cycle from accept to out_valid on an empty pipe; one transfer per cycle sustained.
// Backpressure: in_ready = ~skid_valid, registered, never depends on out_ready or in_valid.
//
// Ports: clk, rst (async, active high); bus (mux_n_1_pipe_if.slave):
//   in_data/sel/in_valid/in_ready  - input beat, channel k at in_data[k*WIDTH +: WIDTH]
//   out_data/out_valid/out_ready   - selected operand
//   flush                          - synchronous drop of both held beats
//   sel_err                        - sticky out-of-range select flag (MUX_SEL_ERR_EN only)
// Optional feature macro: MUX_SEL_ERR_EN. Undefined builds have no sel_err flop or port.
module mux_n_1_pipe #(
  parameter int WIDTH = 32,
  parameter int N     = 4
) (
  input logic          clk,
  input logic          rst,
  mux_n_1_pipe_if.slave bus
);
  localparam int SELW = $clog2(N);

  logic [WIDTH-1:0] m_data_q, m_data_d;
  logic [WIDTH-1:0] s_data_q, s_data_d;
  logic             m_valid_q, m_valid_d;
  logic             s_valid_q, s_valid_d;

  logic [WIDTH-1:0] mux_res;
  logic             accept;
  logic             xfer;

  // Unmatched select values (sel >= N) fall through to the zero default.
  always_comb begin
    mux_res = '0;
    for (int k = 0; k < N; k++) begin
      if (bus.sel == SELW'(k)) mux_res = bus.in_data[k*WIDTH +: WIDTH];
    end
  end

  assign accept = bus.in_valid & ~s_valid_q;
  assign xfer   = m_valid_q & bus.out_ready;

  always_comb begin
    m_data_d  = m_data_q;
    s_data_d  = s_data_q;
    m_valid_d = m_valid_q;
    s_valid_d = s_valid_q;
    if (bus.flush) begin
      // Data registers keep their contents; only the valids drop.
      m_valid_d = 1'b0;
      s_valid_d = 1'b0;
    end else if (s_valid_q && xfer) begin
      // Skid drains into main; in_ready is low so nothing new arrives.
      m_data_d  = s_data_q;
      m_valid_d = 1'b1;
      s_valid_d = 1'b0;
    end else if (!m_valid_q || xfer) begin
      m_valid_d = accept;
      if (accept) m_data_d = mux_res;
    end else if (accept) begin
      // Main is stalled: park the new beat in the skid slot.
      s_data_d  = mux_res;
      s_valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      m_data_q  <= '0;
      s_data_q  <= '0;
      m_valid_q <= 1'b0;
      s_valid_q <= 1'b0;
    end else begin
      m_data_q  <= m_data_d;
      s_data_q  <= s_data_d;
      m_valid_q <= m_valid_d;
      s_valid_q <= s_valid_d;
    end
  end

  assign bus.in_ready  = ~s_valid_q;
  assign bus.out_data  = m_data_q;
  assign bus.out_valid = m_valid_q;

`ifdef MUX_SEL_ERR_EN
  logic sel_hit;
  logic sel_err_q, sel_err_d;

  always_comb begin
    sel_hit = 1'b0;
    for (int k = 0; k < N; k++) begin
      if (bus.sel == SELW'(k)) sel_hit = 1'b1;
    end
  end

  // Sticky: only rst clears it, flush leaves it alone.
  assign sel_err_d = sel_err_q | (accept & ~sel_hit);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) sel_err_q <= 1'b0;
    else     sel_err_q <= sel_err_d;
  end

  assign bus.sel_err = sel_err_q;
`endif
endmodule

// File: tb/tb_mux_n_1_pipe.sv
module tb_mux_n_1_pipe;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  mux_n_1_pipe_if #(.WIDTH(32), .N(4)) if4 ();
  mux_n_1_pipe_if #(.WIDTH(32), .N(3)) if3 ();
  mux_n_1_pipe_if #(.WIDTH(8),  .N(5)) if5 ();

  mux_n_1_pipe #(.WIDTH(32), .N(4)) u4 (.clk(clk), .rst(rst), .bus(if4));
  mux_n_1_pipe #(.WIDTH(32), .N(3)) u3 (.clk(clk), .rst(rst), .bus(if3));
  mux_n_1_pipe #(.WIDTH(8),  .N(5)) u5 (.clk(clk), .rst(rst), .bus(if5));

  localparam logic [31:0] C0 = 32'h11111111;
  localparam logic [31:0] C1 = 32'h22222222;
  localparam logic [31:0] C2 = 32'h33333333;
  localparam logic [31:0] C3 = 32'h44444444;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_all();
    if4.in_valid = 0; if4.flush = 0; if4.out_ready = 0; if4.sel = '0;
    if3.in_valid = 0; if3.flush = 0; if3.out_ready = 0; if3.sel = '0;
    if5.in_valid = 0; if5.flush = 0; if5.out_ready = 0; if5.sel = '0;
    if4.in_data = {C3, C2, C1, C0};
    if3.in_data = {32'hCCCC0003, 32'hBBBB0002, 32'hAAAA0001};
    if5.in_data = '0;
  endtask

  task automatic test_reset();
    #1;
    n_checks++;
    if (if4.out_valid !== 1'b0 || if4.out_data !== 32'h0 || if4.in_ready !== 1'b1)
      $display("FAIL reset_init: valid=%b data=%h ready=%b, need 0/00000000/1",
               if4.out_valid, if4.out_data, if4.in_ready);
    else n_pass++;
`ifdef MUX_SEL_ERR_EN
    n_checks++;
    if (if4.sel_err !== 1'b0) $display("FAIL reset_sel_err: got %b need 0", if4.sel_err);
    else n_pass++;
`endif
    step(); step();
    rst = 0;
    step();
    // Fill both registers, then reset asynchronously between edges.
    if4.in_valid = 1; if4.sel = 2'd0;
    step();
    if4.sel = 2'd1;
    step();
    if4.in_valid = 0;
    n_checks++;
    if (if4.in_ready !== 1'b0 || if4.out_data !== C0)
      $display("FAIL reset_prefill: ready=%b data=%h, need 0/%h", if4.in_ready, if4.out_data, C0);
    else n_pass++;
    #2 rst = 1;
    #1;
    n_checks++;
    if (if4.out_valid !== 1'b0 || if4.out_data !== 32'h0 || if4.in_ready !== 1'b1)
      $display("FAIL reset_async: valid=%b data=%h ready=%b, need 0/00000000/1",
               if4.out_valid, if4.out_data, if4.in_ready);
    else n_pass++;
    #1 rst = 0;
    step();
  endtask

  task automatic test_streaming();
    logic [31:0] exp [4];
    exp[0] = C0; exp[1] = C1; exp[2] = C2; exp[3] = C3;
    if4.out_ready = 1;
    if4.in_valid  = 1;
    for (int i = 0; i < 4; i++) begin
      if4.sel = 2'(i);
      step();
      n_checks++;
      if (if4.out_valid !== 1'b1 || if4.out_data !== exp[i] || if4.in_ready !== 1'b1)
        $display("FAIL stream_%0d: valid=%b data=%h ready=%b, need 1/%h/1",
                 i, if4.out_valid, if4.out_data, if4.in_ready, exp[i]);
      else n_pass++;
    end
    if4.in_valid = 0;
    step();
    n_checks++;
    if (if4.out_valid !== 1'b0) $display("FAIL stream_drain: valid=%b need 0", if4.out_valid);
    else n_pass++;
  endtask

  task automatic test_backpressure();
    if4.out_ready = 0;
    if4.in_valid = 1; if4.sel = 2'd2;
    step();
    if4.sel = 2'd3;
    step();
    if4.in_valid = 0;
    for (int i = 0; i < 3; i++) begin
      n_checks++;
      if (if4.in_ready !== 1'b0 || if4.out_valid !== 1'b1 || if4.out_data !== C2)
        $display("FAIL bp_hold_%0d: ready=%b valid=%b data=%h, need 0/1/%h",
                 i, if4.in_ready, if4.out_valid, if4.out_data, C2);
      else n_pass++;
      step();
    end
    if4.out_ready = 1;
    step();
    n_checks++;
    if (if4.out_valid !== 1'b1 || if4.out_data !== C3 || if4.in_ready !== 1'b1)
      $display("FAIL bp_release: valid=%b data=%h ready=%b, need 1/%h/1",
               if4.out_valid, if4.out_data, if4.in_ready, C3);
    else n_pass++;
    step();
    n_checks++;
    if (if4.out_valid !== 1'b0) $display("FAIL bp_empty: valid=%b need 0", if4.out_valid);
    else n_pass++;
  endtask

  task automatic test_flush();
    bit seen_c0 = 0;
    if4.out_ready = 0;
    if4.in_valid = 1; if4.sel = 2'd2;
    step();
    if4.sel = 2'd3;
    step();
    if4.flush = 1; if4.in_valid = 1; if4.sel = 2'd0;
    step();
    if4.flush = 0; if4.in_valid = 0;
    n_checks++;
    if (if4.out_valid !== 1'b0 || if4.in_ready !== 1'b1)
      $display("FAIL flush_clear: valid=%b ready=%b, need 0/1", if4.out_valid, if4.in_ready);
    else n_pass++;
    if4.out_ready = 1;
    for (int i = 0; i < 4; i++) begin
      if (if4.out_valid === 1'b1 && if4.out_data === C0) seen_c0 = 1;
      step();
    end
    n_checks++;
    if (seen_c0) $display("FAIL flush_discard: flushed beat %h appeared on output", C0);
    else n_pass++;
  endtask

  task automatic test_sel_range();
    if3.out_ready = 1;
    if3.in_valid = 1; if3.sel = 2'd3;
    step();
    if3.in_valid = 0;
    n_checks++;
    if (if3.out_valid !== 1'b1 || if3.out_data !== 32'h0)
      $display("FAIL sel_oor: valid=%b data=%h, need 1/00000000", if3.out_valid, if3.out_data);
    else n_pass++;
`ifdef MUX_SEL_ERR_EN
    n_checks++;
    if (if3.sel_err !== 1'b1) $display("FAIL sel_err_set: got %b need 1", if3.sel_err);
    else n_pass++;
`endif
    if3.flush = 1;
    step();
    if3.flush = 0;
`ifdef MUX_SEL_ERR_EN
    n_checks++;
    if (if3.sel_err !== 1'b1) $display("FAIL sel_err_flush: got %b need 1", if3.sel_err);
    else n_pass++;
`endif
    if3.in_valid = 1; if3.sel = 2'd1;
    step();
    if3.in_valid = 0;
    n_checks++;
    if (if3.out_valid !== 1'b1 || if3.out_data !== 32'hBBBB0002)
      $display("FAIL sel_n3_ch1: valid=%b data=%h, need 1/bbbb0002", if3.out_valid, if3.out_data);
    else n_pass++;
`ifdef MUX_SEL_ERR_EN
    n_checks++;
    if (if3.sel_err !== 1'b1) $display("FAIL sel_err_sticky: got %b need 1", if3.sel_err);
    else n_pass++;
`endif
    step();
  endtask

  task automatic test_random();
    logic [7:0]  q[$];
    logic [39:0] chans;
    logic [7:0]  pick;
    int          s;
    int          n_xfer = 0;
    int          n_bad  = 0;
    for (int cyc = 0; cyc < 10000; cyc++) begin
      chans = 40'({$urandom(), $urandom()});
      s     = int'($urandom_range(0, 7));
      if5.in_data   = chans;
      if5.sel       = 3'(s);
      if5.in_valid  = ($urandom_range(0, 99) < 65);
      if5.out_ready = ($urandom_range(0, 99) < 60);
      if5.flush     = ($urandom_range(0, 999) < 5);
      // The pipe behaves as a two-deep FIFO: ready while fewer than two are held.
      n_checks++;
      if (if5.in_ready !== (q.size() < 2) || if5.out_valid !== (q.size() > 0) ||
          (q.size() > 0 && if5.out_data !== q[0])) begin
        n_bad++;
        $display("FAIL rand_cyc%0d: ready=%b valid=%b data=%h, need %b/%b/%h",
                 cyc, if5.in_ready, if5.out_valid, if5.out_data,
                 q.size() < 2, q.size() > 0, (q.size() > 0) ? q[0] : 8'h00);
      end else n_pass++;
      pick = (s < 5) ? chans[s*8 +: 8] : 8'h00;
      if (if5.flush) begin
        q.delete();
      end else begin
        if (q.size() > 0 && if5.out_ready) begin
          void'(q.pop_front());
          n_xfer++;
        end
        if (if5.in_valid && (q.size() + ((if5.out_ready && q.size() > 0) ? 1 : 0)) < 2)
          q.push_back(pick);
      end
      step();
      if (n_bad > 20) break;
    end
    if5.in_valid = 0; if5.flush = 0; if5.out_ready = 0;
    n_checks++;
    if (n_xfer < 1000) $display("FAIL rand_traffic: only %0d transfers, need >= 1000", n_xfer);
    else n_pass++;
  endtask

  initial begin
    idle_all();
    test_reset();
    test_streaming();
    test_backpressure();
    test_flush();
    test_sel_range();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/mux_n_1_pipe.md
Name: mux_n_1_pipe

Overview:
Parametrised N:1 multiplexer of WIDTH-bit operands with one registered output stage and a valid/ready handshake. A one-entry skid buffer lets it run at full throughput. It is the pipelined successor to the combinational 2:1 32-bit selector. Its first uses in KGP-RISC are the operand-forwarding and writeback-select points, where a downstream stall must not drop data.

Parameters:
- WIDTH, 32, operand width in bits (>=1).
- N, 4, number of input channels (>=2; need not be a power of two).
- SELW, $clog2(N), select width; localparam, not overridable.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous active-high reset.
- in_data  input  N*WIDTH  flattened channels; channel k occupies bits [k*WIDTH +: WIDTH].
- sel  input  SELW  channel select, sampled with in_data on accept.
- in_valid  input  1  upstream offers in_data/sel.
- in_ready  output  1  block can accept this cycle.
- flush  input  1  synchronous pipeline flush.
- out_data  output  WIDTH  selected operand.
- out_valid  output  1  out_data is valid.
- out_ready  input  1  downstream accepts out_data.
- sel_err  output  1  out-of-range select flag; present only with MUX_SEL_ERR_EN.

Behaviour:
- Storage: main register (m_data, m_valid) drives out_data/out_valid; skid register (s_data, s_valid).
- in_ready = ~s_valid. It is combinational from a flop and does not depend on out_ready.
- Selection: the mux result is in_data channel sel. If sel >= N, the result is all-zero.
- Accept = in_valid & in_ready. Output transfer = out_valid & out_ready.
- Cycle rules, all at posedge clk, in priority order:
  1. flush=1: m_valid<=0 and s_valid<=0. Any same-cycle accept is discarded. Data registers keep their contents.
  2. s_valid=1 and output transfer: m <= s, s_valid<=0. No accept is possible this cycle.
  3. m_valid=0 or output transfer: an accept loads m. Otherwise m_valid<=0.
  4. m_valid=1, no output transfer, and accept: the selected value loads s, s_valid<=1.
- Latency is one cycle from accept to out_valid when the pipe is empty.
- Throughput is one transfer per cycle while out_ready=1.
- Ordering is strict FIFO (depth 2). Data is never duplicated or dropped except by flush or rst.
- out_data holds stable while out_valid=1 and out_ready=0.
- Reset values: m_data=0, s_data=0, m_valid=0, s_valid=0. This gives out_valid=0, out_data=0, in_ready=1 (asserted during reset), sel_err=0.
- Reset mid-operation: all held data is lost immediately (asynchronous). Accepting resumes on the first clk after rst deasserts.
- in_valid may drop without a transfer; there is no obligation to hold it. in_ready is never conditioned on in_valid.

Optional Feature:
Macro: MUX_SEL_ERR_EN.
- Defined:
  - Adds the sel_err port.
  - sel_err sets on any accept with sel >= N and stays set (sticky).
  - It clears only on rst; flush does not clear it.
  - The offending beat still propagates as zero data.
- Undefined:
  - No sel_err port and no extra flop.
  - Out-of-range select silently yields zero data.
  - The handshake is identical in both builds.

Test Plan:
1. Reset/idle: assert rst mid-stream with s_valid=1. Required: out_valid=0, out_data=0, in_ready=1 immediately (before the next clk edge).
2. Streaming, N=4, WIDTH=32: channels 0x11111111, 0x22222222, 0x33333333, 0x44444444; sel 0,1,2,3 on consecutive cycles with out_ready=1. Required: out_data 0x11111111, 0x22222222, 0x33333333, 0x44444444 on cycles 1-4, out_valid=1 throughout.
3. Backpressure: out_ready=0 while feeding sel=2 then sel=3. Required: after two accepts in_ready=0, out_data=0x33333333 held stable. Raise out_ready: 0x33333333 then 0x44444444, in_ready returns to 1.
4. Flush with simultaneous accept: both registers full, then flush=1 and in_valid=1 with sel=0. Required: next cycle out_valid=0, in_ready=1, and 0x11111111 never appears on the output.
5. Non-power-of-two, N=3: accept sel=3. Required: out_data=0. With MUX_SEL_ERR_EN, sel_err=1 and it stays 1 after flush and after a later valid sel=1.
6. Random in_valid/out_ready against a scoreboard for 10k cycles with N=5, WIDTH=8. Required: output sequence equals the accepted selected values in order; no loss and no duplicates.
